led_arbiter: RTL
================

LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the 8-bit LED bank (2..8).
REQ-002 Parameter HOLD_CYCLES, default 50_000_000, minimum clk cycles a grant is held before another requester may take the bank (>=1).
REQ-003 Parameter IDLE_PATTERN, default 8'h00, LED value driven when no requester owns the bank.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req  input  NREQ  per-requester request; level, held high while the requester wants the LEDs.
REQ-007 pattern  input  NREQ*8  flattened LED patterns; requester i owns bits [8i+7:8i].
REQ-008 gnt  output  NREQ  one-hot grant; registered; all-zero when idle.
REQ-009 LED  output  8  registered LED bank drive.
REQ-010 busy  output  1  high whenever any grant is active.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE (no owner), HOLD (owner, hold counter running), SHARE (owner, hold satisfied).
REQ-012 IDLE: if any req bit is high, the block SHALL pick the winner round-robin, assert gnt one-hot, load the hold counter with HOLD_CYCLES-1 and enter HOLD, all on the same edge.
REQ-013 Round-robin search SHALL start at index last_owner+1 (mod NREQ) and select the first high req bit; last_owner updates on every grant.
REQ-014 Latency from req rising in IDLE to gnt and LED valid SHALL be exactly one clk cycle.
REQ-015 HOLD: counter decrements by 1 per cycle; on the edge where counter==0 the FSM SHALL enter SHARE; no other requester is granted during HOLD.
REQ-016 HOLD, owner req high: LED SHALL follow the owner's pattern with one cycle latency.
REQ-017 HOLD, owner req low: LED SHALL freeze at its last value and gnt SHALL remain asserted until the counter expires.
REQ-018 SHARE, owner req low, other req pending: re-arbitrate per REQ-012/013 and enter HOLD directly (no IDLE cycle).
REQ-019 SHARE, owner req low, no other req: gnt SHALL clear, LED SHALL take IDLE_PATTERN, FSM to IDLE, on one edge.
REQ-020 SHARE, owner req high, any other req high: the owner SHALL lose the grant and the next round-robin requester SHALL be granted (rotation), entering HOLD.
REQ-021 SHARE, only owner requesting: grant SHALL persist indefinitely with LED tracking its pattern (1-cycle latency).
REQ-022 IDLE: LED SHALL equal IDLE_PATTERN; gnt SHALL equal 0; busy SHALL equal 0.
REQ-023 busy SHALL equal OR-reduction of gnt at all times.
REQ-024 Hold counter width SHALL be $clog2(HOLD_CYCLES+1); HOLD_CYCLES=1 SHALL give exactly one HOLD cycle.
REQ-025 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-026 While reset is low: gnt=0, LED=IDLE_PATTERN, busy=0, FSM=IDLE, counter=0, last_owner=NREQ-1 (so requester 0 has first priority), asynchronously.
REQ-027 Reset asserted mid-HOLD or mid-SHARE SHALL abort the grant immediately without waiting for a clock edge.
REQ-028 First arbitration SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-029 Package led_arb_pkg SHALL hold the state enum (IDLE, HOLD, SHARE) and default NREQ/HOLD_CYCLES constants.
REQ-030 Round-robin selection SHALL be a sub-module led_rr_pick (inputs req, last_owner; outputs one-hot winner, index, any).
REQ-031 All outputs SHALL be driven directly from flops; no combinational path from req/pattern to outputs.

Verification (NREQ=4, HOLD_CYCLES=4, IDLE_PATTERN=8'h00)
REQ-032 Reset held low 3 cycles with req=4'b1111 -> gnt=0, LED=8'h00, busy=0 throughout.
REQ-033 After reset, req=4'b0001, pattern0=8'hA5 -> next cycle gnt=0001, LED=8'hA5, busy=1; pattern0 changed to 8'h3C -> LED=8'h3C one cycle later.
REQ-034 After reset, req=4'b1010 simultaneously -> gnt=0010 first; after 4 HOLD cycles plus SHARE, gnt=1000 (rotation), LED=pattern3.
REQ-035 Owner 0 drops req in 2nd HOLD cycle while pattern0 changes -> LED stays at prior value, gnt=0001 until expiry, then gnt=0, LED=8'h00.
REQ-036 Reset pulsed low mid-HOLD with owner 2 -> gnt=0, LED=8'h00 immediately; after release with req=4'b0101, gnt=0001.
REQ-037 Single requester 3 holds req for 20 cycles -> gnt=1000 continuously, no IDLE cycle, busy=1 throughout.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and default sizing for the LED bank arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StShare
  } arb_state_e;

  localparam int unsigned DefNreq       = 4;
  localparam int unsigned DefHoldCycles = 50_000_000;

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin picker: first set request bit after last_owner, wrapping modulo NREQ.
module led_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j      = 0;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    // k = NREQ wraps back onto last_owner itself, so it is considered last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(last_owner) + k) % NREQ;
      if (!any && req[j[IW-1:0]]) begin
        any                 = 1'b1;
        index               = j[IW-1:0];
        winner[j[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Time-sliced arbiter sharing one 8-bit LED bank between NREQ requesters,
// with a minimum hold time per grant and round-robin rotation afterwards.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NREQ         = DefNreq,
  parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] pattern,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        LED,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  arb_state_e      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last_owner;

  logic [NREQ-1:0] pick_winner;
  logic [IW-1:0]   pick_index;
  logic            pick_any;
  logic            owner_req;
  logic [7:0]      owner_pat;
  logic [7:0]      pick_pat;

  // Masking the current owner makes the same picker serve both fresh
  // arbitration (gnt is zero in idle) and rotation away from the owner.
  led_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req & ~gnt),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .index      (pick_index),
    .any        (pick_any)
  );

  // last_owner always names the current owner while a grant is active.
  assign owner_req = req[last_owner];
  assign owner_pat = pattern[{last_owner, 3'b000} +: 8];
  assign pick_pat  = pattern[{pick_index, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      cnt        <= '0;
      last_owner <= IW'(NREQ - 1);
      gnt        <= '0;
      LED        <= IDLE_PATTERN;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_any) begin
            state      <= StHold;
            cnt        <= CW'(HOLD_CYCLES - 1);
            last_owner <= pick_index;
            gnt        <= pick_winner;
            LED        <= pick_pat;
            busy       <= 1'b1;
          end else begin
            gnt  <= '0;
            LED  <= IDLE_PATTERN;
            busy <= 1'b0;
          end
        end
        StHold: begin
          if (cnt == '0) begin
            state <= StShare;
          end else begin
            cnt <= cnt - 1'b1;
          end
          // A departed owner keeps the bank frozen until its slot expires.
          if (owner_req) begin
            LED <= owner_pat;
          end
        end
        StShare: begin
          if (pick_any) begin
            state      <= StHold;
            cnt        <= CW'(HOLD_CYCLES - 1);
            last_owner <= pick_index;
            gnt        <= pick_winner;
            LED        <= pick_pat;
            busy       <= 1'b1;
          end else if (owner_req) begin
            LED <= owner_pat;
          end else begin
            state <= StIdle;
            gnt   <= '0;
            LED   <= IDLE_PATTERN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          gnt   <= '0;
          LED   <= IDLE_PATTERN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
